// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 Set-2 scancode, event-command and ASCII constants
// for the keycode decoder and its lookup table.
package ps2_keys_pkg;

  // Parser state
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_e;

  // Event command encoding
  localparam logic [2:0] CMD_CHAR  = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_BKSP  = 3'd5;
  localparam logic [2:0] CMD_ENTER = 3'd6;

  // Framing prefixes and modifiers
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Cursor and edit keys
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Letters
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;
  localparam logic [7:0] SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A;
  localparam logic [7:0] SC_N = 8'h31;
  localparam logic [7:0] SC_O = 8'h44;
  localparam logic [7:0] SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15;
  localparam logic [7:0] SC_R = 8'h2D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C;
  localparam logic [7:0] SC_V = 8'h2A;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_Z = 8'h1A;

  // Digits
  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  // Punctuation
  localparam logic [7:0] SC_GRAVE  = 8'h0E;
  localparam logic [7:0] SC_MINUS  = 8'h4E;
  localparam logic [7:0] SC_EQUAL  = 8'h55;
  localparam logic [7:0] SC_LBRACK = 8'h54;
  localparam logic [7:0] SC_RBRACK = 8'h5B;
  localparam logic [7:0] SC_BSLASH = 8'h5D;
  localparam logic [7:0] SC_SEMI   = 8'h4C;
  localparam logic [7:0] SC_QUOTE  = 8'h52;
  localparam logic [7:0] SC_COMMA  = 8'h41;
  localparam logic [7:0] SC_DOT    = 8'h49;
  localparam logic [7:0] SC_SLASH  = 8'h4A;

  // ASCII helpers
  localparam logic [7:0] ASC_NUL   = 8'h00;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CASE  = 8'h20;

  // Keys that still produce events behind an E0 prefix
  function automatic logic is_ext_key(input logic [7:0] c);
    return (c == SC_UP) || (c == SC_DOWN) ||
           (c == SC_LEFT) || (c == SC_RIGHT) ||
           (c == SC_ENTER);
  endfunction

endpackage

// File: rtl/ps2_set2_lut.sv
// Combinational Set-2 make-code lookup: (code, upper, shifted) -> {hit, cmd, ascii}.
// Ports: code in; upper selects letter case; shifted selects symbol row; hit/cmd/ascii out.
module ps2_set2_lut
  import ps2_keys_pkg::*;
(
  input  logic [7:0] code,
  input  logic       upper,
  input  logic       shifted,
  output logic       hit,
  output logic [2:0] cmd,
  output logic [7:0] ascii
);

  logic       letter;
  logic [7:0] lo;
  logic [7:0] hi;

  always_comb begin
    hit    = 1'b1;
    cmd    = CMD_CHAR;
    letter = 1'b0;
    lo     = ASC_NUL;
    hi     = ASC_NUL;
    case (code)
      SC_UP:     cmd = CMD_UP;
      SC_DOWN:   cmd = CMD_DOWN;
      SC_LEFT:   cmd = CMD_LEFT;
      SC_RIGHT:  cmd = CMD_RIGHT;
      SC_BKSP:   cmd = CMD_BKSP;
      SC_ENTER:  cmd = CMD_ENTER;
      SC_SPACE:  begin lo = ASC_SPACE; hi = ASC_SPACE; end
      SC_A:      begin letter = 1'b1; lo = 8'h61; end
      SC_B:      begin letter = 1'b1; lo = 8'h62; end
      SC_C:      begin letter = 1'b1; lo = 8'h63; end
      SC_D:      begin letter = 1'b1; lo = 8'h64; end
      SC_E:      begin letter = 1'b1; lo = 8'h65; end
      SC_F:      begin letter = 1'b1; lo = 8'h66; end
      SC_G:      begin letter = 1'b1; lo = 8'h67; end
      SC_H:      begin letter = 1'b1; lo = 8'h68; end
      SC_I:      begin letter = 1'b1; lo = 8'h69; end
      SC_J:      begin letter = 1'b1; lo = 8'h6A; end
      SC_K:      begin letter = 1'b1; lo = 8'h6B; end
      SC_L:      begin letter = 1'b1; lo = 8'h6C; end
      SC_M:      begin letter = 1'b1; lo = 8'h6D; end
      SC_N:      begin letter = 1'b1; lo = 8'h6E; end
      SC_O:      begin letter = 1'b1; lo = 8'h6F; end
      SC_P:      begin letter = 1'b1; lo = 8'h70; end
      SC_Q:      begin letter = 1'b1; lo = 8'h71; end
      SC_R:      begin letter = 1'b1; lo = 8'h72; end
      SC_S:      begin letter = 1'b1; lo = 8'h73; end
      SC_T:      begin letter = 1'b1; lo = 8'h74; end
      SC_U:      begin letter = 1'b1; lo = 8'h75; end
      SC_V:      begin letter = 1'b1; lo = 8'h76; end
      SC_W:      begin letter = 1'b1; lo = 8'h77; end
      SC_X:      begin letter = 1'b1; lo = 8'h78; end
      SC_Y:      begin letter = 1'b1; lo = 8'h79; end
      SC_Z:      begin letter = 1'b1; lo = 8'h7A; end
      SC_0:      begin lo = 8'h30; hi = 8'h29; end
      SC_1:      begin lo = 8'h31; hi = 8'h21; end
      SC_2:      begin lo = 8'h32; hi = 8'h40; end
      SC_3:      begin lo = 8'h33; hi = 8'h23; end
      SC_4:      begin lo = 8'h34; hi = 8'h24; end
      SC_5:      begin lo = 8'h35; hi = 8'h25; end
      SC_6:      begin lo = 8'h36; hi = 8'h5E; end
      SC_7:      begin lo = 8'h37; hi = 8'h26; end
      SC_8:      begin lo = 8'h38; hi = 8'h2A; end
      SC_9:      begin lo = 8'h39; hi = 8'h28; end
      SC_GRAVE:  begin lo = 8'h60; hi = 8'h7E; end
      SC_MINUS:  begin lo = 8'h2D; hi = 8'h5F; end
      SC_EQUAL:  begin lo = 8'h3D; hi = 8'h2B; end
      SC_LBRACK: begin lo = 8'h5B; hi = 8'h7B; end
      SC_RBRACK: begin lo = 8'h5D; hi = 8'h7D; end
      SC_BSLASH: begin lo = 8'h5C; hi = 8'h7C; end
      SC_SEMI:   begin lo = 8'h3B; hi = 8'h3A; end
      SC_QUOTE:  begin lo = 8'h27; hi = 8'h22; end
      SC_COMMA:  begin lo = 8'h2C; hi = 8'h3C; end
      SC_DOT:    begin lo = 8'h2E; hi = 8'h3E; end
      SC_SLASH:  begin lo = 8'h2F; hi = 8'h3F; end
      default:   hit = 1'b0;
    endcase

    // Letters fold case by clearing bit 5; others pick a row
    ascii = ASC_NUL;
    if (hit && cmd == CMD_CHAR) begin
      if (letter)
        ascii = upper ? (lo & ~ASC_CASE) : lo;
      else
        ascii = shifted ? hi : lo;
    end
  end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 Set-2 byte stream to single-cycle key events (ASCII / cursor cmds).
// Ports: clk, rst (async high), enable, rx_done/rx_data in;
//   ev_valid/ev_cmd/ev_ascii, shift_o, caps_o out. Macro: PS2_CAPSLOCK_EN.
module ps2_keycode_decoder
  import ps2_keys_pkg::*;
#(
  parameter bit SHIFT_AFFECTS_DIGITS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       ev_valid,
  output logic [2:0] ev_cmd,
  output logic [7:0] ev_ascii,
  output logic       shift_o,
  output logic       caps_o
);

  ps2_state_e state;
  logic       lshift;
  logic       rshift;
  logic       caps_w;
  logic       shift_w;

  logic       lut_hit;
  logic [2:0] lut_cmd;
  logic [7:0] lut_ascii;

  logic       prefix;
  logic       make_plain;
  logic       make_ext;
  logic       fire;

  assign shift_w = lshift | rshift;
  assign shift_o = shift_w;

  assign prefix = (rx_data == SC_EXT) ||
                  (rx_data == SC_BRK);
  assign make_plain = rx_done && !prefix &&
                      (state == ST_IDLE);
  assign make_ext = rx_done && !prefix &&
                    (state == ST_EXT);

  // Behind E0 only arrows and keypad enter are keys
  assign fire = enable && lut_hit &&
                (make_plain ||
                 (make_ext && is_ext_key(rx_data)));

  ps2_set2_lut u_lut (
    .code    (rx_data),
    .upper   (shift_w ^ caps_w),
    .shifted (shift_w & SHIFT_AFFECTS_DIGITS),
    .hit     (lut_hit),
    .cmd     (lut_cmd),
    .ascii   (lut_ascii)
  );

`ifdef PS2_CAPSLOCK_EN
  logic caps_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      caps_q <= 1'b0;
    else if (make_plain && rx_data == SC_CAPS)
      caps_q <= ~caps_q;
  end

  assign caps_w = caps_q;
`else
  assign caps_w = 1'b0;
`endif

  assign caps_o = caps_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lshift   <= 1'b0;
      rshift   <= 1'b0;
      ev_valid <= 1'b0;
      ev_cmd   <= CMD_CHAR;
      ev_ascii <= ASC_NUL;
    end else begin
      ev_valid <= fire;
      if (fire) begin
        ev_cmd   <= lut_cmd;
        ev_ascii <= lut_ascii;
      end
      if (rx_done) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SC_EXT)
              state <= ST_EXT;
            else if (rx_data == SC_BRK)
              state <= ST_BRK;
            else if (rx_data == SC_LSHIFT)
              lshift <= 1'b1;
            else if (rx_data == SC_RSHIFT)
              rshift <= 1'b1;
          end
          ST_EXT: begin
            if (rx_data == SC_BRK)
              state <= ST_EXT_BRK;
            else if (rx_data != SC_EXT)
              state <= ST_IDLE;
          end
          ST_BRK: begin
            state <= ST_IDLE;
            if (rx_data == SC_LSHIFT)
              lshift <= 1'b0;
            if (rx_data == SC_RSHIFT)
              rshift <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_keycode_decoder.md
# ps2_keycode_decoder

Translates the raw PS/2 Set-2 byte stream from `ps2_scanner` into single-cycle key events: printable ASCII characters and cursor/edit commands. It sits between `ps2_scanner` and the text-display tile writer. It strips make/break/extended framing, tracks Shift and Caps Lock state, and emits one event per key press (never on release). The downstream stage uses `ev_ascii` as the tile BRAM write data and `ev_cmd` to move the cursor.

## Interface

Parameters:
- `SHIFT_AFFECTS_DIGITS`, 1: when 1, Shift maps digits and punctuation to their US-layout shifted symbols; when 0, only letters are affected.

Ports:
- `clk`  in  1  system clock (75 MHz domain).
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  when 0, bytes are still parsed and modifier state tracked, but no events are emitted.
- `rx_done`  in  1  one-cycle strobe from `ps2_scanner`; `rx_data` is valid this cycle.
- `rx_data`  in  8  received scancode byte.
- `ev_valid`  out  1  one-cycle event strobe.
- `ev_cmd`  out  3  0 CHAR, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 BKSP, 6 ENTER, 7 reserved.
- `ev_ascii`  out  8  ASCII code when `ev_cmd`=CHAR; 8'h00 otherwise.
- `shift_o`  out  1  current Shift state (left OR right held).
- `caps_o`  out  1  current Caps Lock latch.

## Operation

- Parser FSM states:
  - IDLE
  - EXT: after E0.
  - BRK: after F0.
  - EXT_BRK: after E0 F0.
- Transitions occur only on `rx_done`:
  - IDLE: E0 → EXT; F0 → BRK; any other byte is a make code → MAKE handling, stay IDLE.
  - EXT: F0 → EXT_BRK; E0 → stay EXT; other byte is an extended make → IDLE.
  - BRK: any byte is a break code → IDLE.
  - EXT_BRK: any byte is an extended break → IDLE.
  - E1 and any unlisted byte in IDLE are ordinary make codes, unmapped, so no event.
- Modifier tracking:
  - 12 (L-Shift) and 59 (R-Shift) make set the individual held bit; the matching break clears it. `shift_o` = lshift | rshift.
  - 58 (Caps Lock) make toggles `caps_o`. Typematic repeats of 58 toggle again; this is accepted behaviour.
  - 12/59 seen with an E0 prefix (fake shifts) are ignored.
- Event generation, on make only and only when `enable`=1:
  - 75/72/6B/74, with or without E0 → UP/DOWN/LEFT/RIGHT.
  - 66 → BKSP; 5A (with or without E0) → ENTER.
  - Letters: uppercase iff shift XOR caps; e.g. 1C → 'a'(61) / 'A'(41).
  - Digits, space 29, and punctuation → ASCII. Shifted symbols are used when shift=1 and `SHIFT_AFFECTS_DIGITS`=1.
  - Unmapped codes produce no event.
- Break codes never produce events. Typematic repeat makes each produce an event.

## Timing

- Latency: `ev_valid` is asserted exactly 1 cycle after the `rx_done` carrying the make byte. All outputs are registered.
- `ev_cmd`/`ev_ascii` hold their value until the next event. They are only meaningful while `ev_valid`=1.
- Shift/caps updates are visible on `shift_o`/`caps_o` 1 cycle after the byte. A character on the very next byte uses the updated state.
- Back-to-back `rx_done` on consecutive cycles must be handled with no byte lost.
- `rx_done` is at most 1 cycle wide by contract; a held strobe is treated as repeated bytes.
- Reset, including mid-sequence, forces:
  - FSM = IDLE;
  - lshift = rshift = caps = 0;
  - `ev_valid` = 0, `ev_cmd` = 0, `ev_ascii` = 8'h00.
  - A partial E0/F0 prefix is discarded.
- An `enable` toggle mid-sequence does not disturb the FSM.

## Configuration

- `PS2_CAPSLOCK_EN`:
  - Defined: Caps Lock is tracked as above.
  - Undefined: the caps latch does not exist, `caps_o` is tied to 0, and 58 is unmapped.

## Structure

- Shared package `ps2_keys_pkg` holds:
  - scancode constants: prefixes E0/F0, shift/caps codes, arrow, edit and letter codes;
  - `ev_cmd` encoding constants;
  - the ASCII constants used by the LUT.
- Sub-module `ps2_set2_lut` is purely combinational: (scancode, upper, shifted) → {hit, cmd, ascii}. The FSM and modifier registers stay in `ps2_keycode_decoder`.

## Test plan

- 1C → `ev_valid` 1 cycle later with CHAR, 8'h61. Then F0 1C → no event.
- 12, 1C, F0 1C, F0 12, 1C → events 41 then 61. `shift_o` is 1 between the 12 make and the 12 break.
- With `PS2_CAPSLOCK_EN`: 58, F0 58, 12, 1C → 61 (shift XOR caps). Then F0 12, 1C → 41.
- E0 75, E0 F0 75, 72, 6B → UP, DOWN, LEFT. The release produces no event.
- E0 sent, then `rst` pulsed, then 1C → CHAR 61 (prefix discarded). All outputs read 0 during reset.
- `enable`=0: 12, 1C → no events, `shift_o`=1. Then `enable`=1, 1C → 41.
